// File: rtl/inport_capture_pkg.sv
// Shared definitions for the inport capture path: debounce state encoding
// and the default sizing of the switch word, debounce window and FIFO.
package inport_capture_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_FIFO_DEPTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/inport_capture_button_debouncer.sv
// Two-flop synchronizer plus debounce FSM for the load button; emits a
// registered single-cycle pulse once per debounced press.
module button_debouncer
    import inport_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic in_reset,
    input  logic in_button,
    output logic out_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_btn_meta;
    logic          r_btn_sync;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    db_state_t     w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_press;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!in_reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_btn_meta <= in_button;
            r_btn_sync <= r_btn_meta;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_press    <= w_press;
        end
    end

    // NOTE: defaults first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_btn_sync) begin
                    w_state_next = ST_PRESS_WAIT;
                    w_cnt_next   = CW'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_btn_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                    w_press      = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!r_btn_sync) begin
                    w_state_next = ST_RELEASE_WAIT;
                    w_cnt_next   = CW'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_btn_sync) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign out_press = r_press;

endmodule

// File: rtl/inport_capture.sv
// Inport producer: synchronizes switches, captures them on each debounced
// load press into a first-word fall-through FIFO popped by CPU read edges.
module inport_capture
    import inport_capture_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          in_reset,
    input  logic [DATA_WIDTH-1:0]         in_switches,
    input  logic                          in_load_button,
    input  logic                          in_inport_read,
    input  logic                          in_clear_overflow,
    output logic [DATA_WIDTH-1:0]         out_inport_data,
    output logic                          out_data_valid,
    output logic                          out_fifo_full,
    output logic                          out_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   out_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    logic [DATA_WIDTH-1:0] r_sw_meta;
    logic [DATA_WIDTH-1:0] r_sw_sync;
    logic [DATA_WIDTH-1:0] r_sw_hold;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNTW-1:0]       r_count;
    logic                  r_read_d;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_full;
    logic                  r_overflow;

    logic                  w_press;
    logic                  w_pop;
    logic                  w_full_now;
    logic                  w_push_ok;
    logic                  w_drop;
    logic [AW-1:0]         w_rd_ptr_next;
    logic [CNTW-1:0]       w_after_pop;
    logic [CNTW-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0] w_head;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .in_reset  (in_reset),
        .in_button (in_load_button),
        .out_press (w_press)
    );

    assign w_pop         = in_inport_read & ~r_read_d & (r_count != '0);
    assign w_full_now    = (r_count == CNTW'(FIFO_DEPTH));
    assign w_push_ok     = w_press & (~w_full_now | w_pop);
    assign w_drop        = w_press & w_full_now & ~w_pop;
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
    assign w_after_pop   = r_count - CNTW'(w_pop);
    assign w_count_next  = w_after_pop + CNTW'(w_push_ok);

    // Head of the next cycle; a write into an otherwise empty FIFO bypasses memory.
    always_comb begin
        w_head = r_data;
        if (w_push_ok && (w_after_pop == '0)) begin
            w_head = r_sw_hold;
        end else if (w_count_next != '0) begin
            w_head = r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!in_reset) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_sw_hold  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_read_d   <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sw_meta  <= in_switches;
            r_sw_sync  <= r_sw_meta;
            r_sw_hold  <= r_sw_sync;
            r_wr_ptr   <= r_wr_ptr + AW'(w_push_ok);
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_read_d   <= in_inport_read;
            r_data     <= w_head;
            r_valid    <= (w_count_next != '0);
            r_full     <= (w_count_next == CNTW'(FIFO_DEPTH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (in_clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_sw_hold;
        end
    end

    assign out_inport_data = r_data;
    assign out_data_valid  = r_valid;
    assign out_fifo_full   = r_full;
    assign out_overflow    = r_overflow;
    assign out_count       = r_count;

endmodule

// File: doc/inport_capture.md
Name: inport_capture

Overview:
- Producer side of the CPU input port.
- Synchronizes and debounces board switches plus a "load" push-button. On each debounced press, it captures the switch word into a small FIFO.
- The FIFO head is presented as the inport data word. The datapath pops one entry per inport read.
- Sits between board pins and the datapath inport input. It is the counterpart of the outport/seven-segment path.

Parameters:
- DATA_WIDTH, 32, width of captured switch word and inport data.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to change the debounced button level (>=2).
- FIFO_DEPTH, 4, number of buffered words (power of two, >=2).

Ports:
- clk  input  1  system clock (divided clock domain of the CPU).
- in_reset  input  1  synchronous, active-low reset.
- in_switches  input  DATA_WIDTH  raw asynchronous switch levels.
- in_load_button  input  1  raw asynchronous push-button, high = pressed.
- in_inport_read  input  1  CPU inport read enable; may stay high for several cycles.
- in_clear_overflow  input  1  synchronous clear of the sticky overflow flag.
- out_inport_data  output  DATA_WIDTH  FIFO head (first-word fall-through).
- out_data_valid  output  1  FIFO non-empty.
- out_fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- out_overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- out_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While in_reset==0 at a clk rising edge:
  - synchronizers, debounce counter, pointers, count and overflow are cleared;
  - FSM goes to IDLE;
  - out_inport_data=0, out_data_valid=0, out_fifo_full=0, out_overflow=0, out_count=0.
- Reset mid-press discards all state. A button still held after reset is re-debounced from IDLE and captured once.
- Synchronization: two-flop synchronizer on in_load_button and on every in_switches bit.
- Debounce FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, with counter cnt:
  - IDLE: sync_btn=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT: sync_btn=0 -> IDLE, cnt=0. cnt==DEBOUNCE_CYCLES-1 -> PRESSED and issue push. Otherwise cnt++.
  - PRESSED: sync_btn=0 -> RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: sync_btn=1 -> PRESSED, cnt=0. cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Exactly one push per debounced press. The pushed word is the synchronized switch value on the cycle of the PRESS_WAIT->PRESSED transition.
- Latency: button high sampled at edge E0 -> out_data_valid high after edge E0+DEBOUNCE_CYCLES+2. This assumes the FIFO was empty and no read occurs.
- Pop:
  - Internal rising-edge detect on in_inport_read.
  - Pop occurs on the edge following the cycle where in_inport_read goes 0->1 and the FIFO is non-empty.
  - Holding in_inport_read high pops only once.
  - Data is valid throughout the read cycle, because it is the current head.
- Empty: a read edge is ignored. out_inport_data keeps the last popped value (0 after reset). out_data_valid=0.
- Full:
  - A push with no pop in the same cycle is dropped. Contents are unchanged and out_overflow<=1.
  - A push and pop in the same cycle while full both succeed. Count is unchanged and no overflow is flagged.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, head advances.
- Pointers wrap modulo FIFO_DEPTH. out_count ranges 0..FIFO_DEPTH.
- in_clear_overflow clears out_overflow. If a drop happens in the same cycle, the drop wins and out_overflow stays 1.
- All outputs are registered.

Decomposition:
- Shared package holds:
  - debounce state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - default DATA_WIDTH/DEBOUNCE_CYCLES/FIFO_DEPTH constants.
- One sub-module, button_debouncer: synchronizer plus debounce FSM. Outputs a single-cycle press pulse.
- The FIFO and read-edge logic stay in inport_capture.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset: hold in_reset=0 for 2 edges with button high -> all outputs 0.
- Single press: after release of reset, set switches=32'h88 and hold the button for 10 cycles, then release.
  - Expected: out_data_valid rises exactly 6 edges after button sampled high; out_inport_data=32'h88, out_count=1.
  - Then hold in_inport_read for 3 cycles -> exactly one pop, out_data_valid=0, data stays 32'h88.
- Bounce: toggle the button every 2 cycles for 20 cycles, then hold low -> no push, out_count=0.
- Overflow: 5 clean presses with switches 1,2,3,4,5, no reads.
  - Expected: out_fifo_full=1, out_overflow=1, pops return 1,2,3,4.
  - Assert in_clear_overflow -> out_overflow=0.
- Full with concurrent read: FIFO full with 1..4. Issue a read edge on the same cycle as the 5th push (value 5).
  - Expected: no overflow, out_count stays 4, subsequent pops return 2,3,4,5.
- Reset mid-press: assert reset during PRESS_WAIT, then release reset with the button still held -> exactly one capture after DEBOUNCE_CYCLES+2 edges.
